mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and HI/LO register width; legal values are 4 to 64.
REQ-002 Parameter SIGNED_EN, default 1: when 0, signed opcodes execute as their unsigned forms.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset_in  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request; sampled only in IDLE.
REQ-006 op  in  2  opcode: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 a  in  WIDTH  operand A (dividend / multiplicand).
REQ-008 b  in  WIDTH  operand B (divisor / multiplier).
REQ-009 hi  out  WIDTH  HI register: product upper half, or remainder.
REQ-010 lo  out  WIDTH  LO register: product lower half, or quotient.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle completion pulse; replaces the control unit's mult_stop/div_stop.
REQ-013 div_zero  out  1  one-cycle pulse on a divide by zero.

Function
REQ-014 FSM states: IDLE, LOAD, ITER, FIX, DONE.
REQ-015 IDLE with start=1 at edge 0: capture a, b and op, go to LOAD, and raise busy.
REQ-016 Operands are registered at edge 0; changes to a, b or op while busy are ignored.
REQ-017 LOAD (one cycle): form magnitudes (two's-complement negate if signed op and MSB=1), record result signs, clear iteration counter.
REQ-018 ITER (exactly WIDTH cycles): MULT/MULTU radix-2 shift-add on magnitudes into a 2*WIDTH accumulator; DIV/DIVU one restoring-division step per cycle.
REQ-019 Iteration counter width is clog2(WIDTH)+1; ITER exits when the count reaches WIDTH-1.
REQ-020 FIX (one cycle): negate the product if signs differ; negate the quotient if the signs of a and b differ; remainder takes the sign of a; write hi/lo.
REQ-021 Result mapping: mult hi=product[2W-1:W], lo=product[W-1:0]; div lo=quotient, hi=remainder.
REQ-022 DONE: done=1 for exactly one cycle, in the cycle starting at edge WIDTH+2; busy=0 in that same cycle; next state IDLE.
REQ-023 hi/lo change only at the FIX edge and hold their values otherwise.
REQ-024 DIV/DIVU with captured b=0: go directly to DONE at edge 1, pulse div_zero together with done, and leave hi/lo unchanged.
REQ-025 start asserted while busy or in DONE is ignored; it is not queued.
REQ-026 Signed overflow case (most-negative / -1): lo=most-negative value (wraps), hi=0, no div_zero.
REQ-027 start held high continuously: a new operation begins at the first IDLE edge after DONE.

Reset
REQ-028 reset_in=0 forces state IDLE, counter 0, and hi, lo, busy, done, div_zero all 0 immediately, independent of clk.
REQ-029 Reset asserted mid-operation discards the operation; no done pulse follows.
REQ-030 The first start is accepted at the first rising edge after reset_in returns high.

Structure
REQ-031 Shared package md_pkg holds the op encodings, FSM state encodings and the WIDTH default.
REQ-032 Sub-module md_fsm holds the state register, iteration counter and busy/done/div_zero generation.
REQ-033 The shift-add/restoring datapath stays in mult_div_unit.

Verification
REQ-034 WIDTH=32, MULT a=FFFFFFFD (-3), b=7 -> done at edge-0+34 cycles, hi=FFFFFFFF, lo=FFFFFFEB.
REQ-035 MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE; and SIGNED_EN=0 with MULT on the same operands -> same result.
REQ-036 DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; and DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_zero=0.
REQ-037 DIVU b=0 with hi/lo preloaded to 5/6 -> done and div_zero both high one cycle later, hi=5, lo=6, busy low after that.
REQ-038 start pulsed again at cycle 5 of an operation -> ignored, exactly one done; reset_in=0 at cycle 10 -> all outputs 0 at once, and no done pulse.
REQ-039 WIDTH=8, MULTU a=FF, b=FF -> done after 10 cycles, hi=FE, lo=01.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states and the default width.
package md_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Bit 0 of the opcode marks the unsigned forms; bit 1 selects divide.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op[0] == 1'b0);
  endfunction

endpackage

// File: rtl/md_fsm.sv
// Sequencer for the multiply/divide unit: state register, iteration counter and
// the registered busy/done/div_zero status outputs.
module md_fsm
  import md_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic   clk,
  input  logic   i_rst_n,
  input  logic   i_start,
  input  logic   i_div_op,
  input  logic   i_b_zero,
  output state_e o_state,
  output logic   o_busy,
  output logic   o_done,
  output logic   o_div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_div_zero;

  // State transitions, iteration count and status flags, all registered.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done     <= 1'b0;
          r_div_zero <= 1'b0;
          if (i_start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_cnt <= '0;
          // A zero divisor skips the iterations and reports straight away.
          if (i_div_op && i_b_zero) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
          end else begin
            r_state <= ST_ITER;
          end
        end
        ST_ITER: begin
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_FIX: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_done     <= 1'b0;
          r_div_zero <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_div_zero <= 1'b0;
        end
      endcase
    end
  end

  assign o_state    = r_state;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up before the HI/LO write.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_e             w_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  md_fsm #(.WIDTH(WIDTH)) u_fsm (
    .clk        (clk),
    .i_rst_n    (reset_in),
    .i_start    (start),
    .i_div_op   (r_op[1]),
    .i_b_zero   (w_b_zero),
    .o_state    (w_state),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (div_zero)
  );

  assign w_signed = SIGNED_EN && op_is_signed(r_op);
  assign w_b_zero = (r_b == '0);
  assign w_mag_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  // Multiply: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide: accumulator is {partial remainder, dividend/quotient bits}.
  assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mag_b;
  assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ge};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // Operand capture, magnitude/sign setup, iteration and result write-back.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_op    <= 2'b00;
      r_a     <= '0;
      r_b     <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (w_state)
        ST_IDLE: begin
          if (start) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
          end else begin
            r_op <= r_op;
          end
        end
        ST_LOAD: begin
          r_mag_a <= w_mag_a;
          r_mag_b <= w_mag_b;
          r_neg_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= w_signed && r_a[WIDTH-1];
          r_acc   <= {{WIDTH{1'b0}}, (r_op[1] ? w_mag_a : w_mag_b)};
        end
        ST_ITER: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
        end
        ST_FIX: begin
          if (r_op[1]) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
